// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sha256_pkg
// Purpose : Shared SHA-256 constants and helpers. Holds the 64 round
//           constants K, the initial hash value H0 (also used by the hash
//           core), the scheduler state encoding and the small-sigma
//           functions used for message expansion.
// Ports   : n/a (package)
// Rev     : 1.0  initial release
// ============================================================================
package sha256_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [31:0] c_sha256_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] c_sha256_h0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Rotate right; only ever called with constant amounts 1..31.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
// Module  : sha256_k_rom
// Purpose : Combinational round-constant lookup, K[addr].
// Ports   : addr  in  6   round index 0..63
//           data  out 32  round constant K[addr]
// Rev     : 1.0  initial release
// ============================================================================
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] data
);

  always_comb begin
    data = c_sha256_k[addr];
  end

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha256_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sha256_msg_scheduler
// Purpose : Loads one 512-bit block as sixteen 32-bit words, then streams
//           the 64 message-schedule words Wt with round constants Kt to the
//           hash core, one round per out_valid/out_ready handshake. The
//           schedule is expanded in place in a 16-word sliding window.
// Ports   : clk, rst_n (async, active-low), clear_i (sync abort)
//           in_valid/in_ready/in_word      : block word input stream
//           out_valid/out_ready            : round output handshake
//           wt_o, kt_o, round_o, last_o    : current round payload
// Rev     : 1.0  initial release
// ============================================================================
module sha256_msg_scheduler
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wt_o,
  output logic [31:0] kt_o,
  output logic [5:0]  round_o,
  output logic        last_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ld_cnt;
  logic [5:0]  r_rnd;
  logic [31:0] r_win [0:15];

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_last_rnd;
  logic        w_last_word;
  logic [31:0] w_expand;

  // Handshake strobes are decoded from state only; clear_i suppresses
  // both so an abort always wins over a same-cycle transfer.
  assign in_ready    = (r_state == LOAD);
  assign out_valid   = (r_state == EMIT);
  assign w_in_fire   = in_valid  & in_ready  & ~clear_i;
  assign w_out_fire  = out_valid & out_ready & ~clear_i;
  assign w_last_rnd  = (r_rnd == 6'd63);
  assign w_last_word = (r_ld_cnt == 4'd15);

  // W_{t+16} from the current window W_t..W_{t+15}.
  assign w_expand = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_in_fire && w_last_word) w_state_nxt = EMIT;
        EMIT:    if (w_out_fire && w_last_rnd) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  // ----------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt <= 4'd0;
      r_rnd    <= 6'd0;
    end else if (clear_i) begin
      r_ld_cnt <= 4'd0;
      r_rnd    <= 6'd0;
    end else begin
      // 4-bit counter wraps to 0 naturally on the sixteenth word.
      if (w_in_fire) begin
        r_ld_cnt <= r_ld_cnt + 4'd1;
        if (w_last_word) r_rnd <= 6'd0;
      end
      if (w_out_fire) begin
        r_rnd <= w_last_rnd ? 6'd0 : r_rnd + 6'd1;
      end
    end
  end

  // -------------------------------------------------------------- window
  // Load writes slot ld_cnt; each emitted round shifts the window down by
  // one and appends the next expanded word. Rounds 0..15 therefore echo
  // the loaded words without any special-case path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else if (w_in_fire) begin
      r_win[r_ld_cnt] <= in_word;
    end else if (w_out_fire) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_expand;
    end
  end

  // ------------------------------------------------------------- outputs
  sha256_k_rom u_k_rom (
    .addr (r_rnd),
    .data (kt_o)
  );

  assign wt_o    = r_win[0];
  assign round_o = r_rnd;
  assign last_o  = out_valid & w_last_rnd;

endmodule : sha256_msg_scheduler
`default_nettype wire

// File: tb/tb_sha256_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_msg_scheduler
// Purpose : Directed self-checking bench for sha256_msg_scheduler. Expected
//           schedule words come from an independent FIPS 180-4 recurrence
//           over the loaded block plus hand-computed anchor values.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_sha256_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wt_o;
  logic [31:0] kt_o;
  logic [5:0]  round_o;
  logic        last_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] blk   [0:15];
  logic [31:0] exp_w [0:63];
  logic [31:0] k_ref [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wt_o      (wt_o),
    .kt_o      (kt_o),
    .round_o   (round_o),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  // Reference sigmas written as explicit bit concatenations.
  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present the 16 words of blk; optional idle cycle before each word.
  task automatic load_block(input bit gapped);
    for (int i = 0; i < 16; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        in_word  = 32'hdeadbeef;
        tick();
        chk($sformatf("gap%0d_ovalid", i), 32'(out_valid), 32'd0);
      end
      chk($sformatf("ld%0d_iready", i), 32'(in_ready), 32'd1);
      chk($sformatf("ld%0d_ovalid", i), 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_word  = blk[i];
      tick();
      in_valid = 1'b0;
    end
  endtask

  // Check and consume rounds [from, to); optional 5-cycle stall at one round.
  task automatic run_rounds(input int from, input int to, input int stall_at);
    for (int t = from; t < to; t++) begin
      chk($sformatf("r%0d_ovalid", t), 32'(out_valid), 32'd1);
      chk($sformatf("r%0d_round", t), 32'(round_o), 32'(t));
      chk($sformatf("r%0d_wt", t), wt_o, exp_w[t]);
      chk($sformatf("r%0d_kt", t), kt_o, k_ref[t]);
      chk($sformatf("r%0d_last", t), 32'(last_o), 32'(t == 63));
      if (t == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk($sformatf("stall%0d_round", s), 32'(round_o), 32'(t));
          chk($sformatf("stall%0d_wt", s), wt_o, exp_w[t]);
          chk($sformatf("stall%0d_kt", s), kt_o, k_ref[t]);
          chk($sformatf("stall%0d_ovalid", s), 32'(out_valid), 32'd1);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  // Full "abc" block with hand-computed anchors at W16, W17 and round 63.
  task automatic run_abc(input int stall_at);
    set_abc();
    load_block(1'b0);
    run_rounds(0, 16, stall_at);
    chk("abc_w16", wt_o, 32'h61626380);
    run_rounds(16, 17, stall_at);
    chk("abc_w17", wt_o, 32'h000f0000);
    run_rounds(17, 63, stall_at);
    chk("abc_k63", kt_o, 32'hc67178f2);
    chk("abc_last63", 32'(last_o), 32'd1);
    run_rounds(63, 64, stall_at);
    chk("abc_done_iready", 32'(in_ready), 32'd1);
    chk("abc_done_ovalid", 32'(out_valid), 32'd0);
    chk("abc_done_round", 32'(round_o), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear_i   = 1'b0;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_wt", wt_o, 32'd0);
    chk("rst_kt", kt_o, 32'h428a2f98);
    chk("rst_round", 32'(round_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Unstalled abc block, then the same block with a stall at round 20
    run_abc(-1);
    run_abc(20);

    // Gapped all-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    build_model();
    load_block(1'b1);
    run_rounds(0, 64, -1);

    // Asynchronous reset in the middle of EMIT
    set_abc();
    load_block(1'b0);
    run_rounds(0, 30, -1);
    chk("pre_rst_round", 32'(round_o), 32'd30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(out_valid), 32'd0);
    chk("mid_rst_iready", 32'(in_ready), 32'd1);
    chk("mid_rst_round", 32'(round_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ovalid", 32'(out_valid), 32'd0);
    run_abc(-1);

    // clear_i on the cycle the 16th word is offered
    set_abc();
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_word  = blk[i];
      tick();
    end
    in_word = blk[15];
    clear_i = 1'b1;
    tick();
    clear_i  = 1'b0;
    in_valid = 1'b0;
    chk("clr_ld_iready", 32'(in_ready), 32'd1);
    chk("clr_ld_ovalid", 32'(out_valid), 32'd0);
    tick();
    chk("clr_ld_ovalid2", 32'(out_valid), 32'd0);
    // A fresh 16-word load must be needed (ld_cnt restarted at 0)
    load_block(1'b0);
    run_rounds(0, 10, -1);

    // clear_i in EMIT at round 10, overriding a same-cycle handshake
    clear_i   = 1'b1;
    out_ready = 1'b1;
    tick();
    clear_i   = 1'b0;
    out_ready = 1'b0;
    chk("clr_em_ovalid", 32'(out_valid), 32'd0);
    chk("clr_em_iready", 32'(in_ready), 32'd1);
    chk("clr_em_round", 32'(round_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_sha256_msg_scheduler
`default_nettype wire
